// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;

  localparam int INST_ADDR_BUS   = 32;
  localparam int INST_DATA_BUS   = 32;
  localparam int FETCH_STATE_BUS = 2;
  localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [FETCH_STATE_BUS-1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_DATA_BUS-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, word}; DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; the top masks the head while the queue is empty.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch.sv
// Instruction fetch: owns the fetch PC, issues credit-limited imem requests, buffers responses.
// FETCH_BYPASS_EN: a response arriving at an empty queue is presented in the same cycle.
module fetch
  import fetch_pkg::*;
#(
  parameter int                       DEPTH    = 2,
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect_enable,
  input  logic [INST_ADDR_BUS-1:0] redirect_addr,
  output logic                     imem_request,
  output logic [INST_ADDR_BUS-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_valid,
  input  logic [INST_DATA_BUS-1:0] imem_data,
  output logic [INST_ADDR_BUS-1:0] program_counter,
  output logic [INST_DATA_BUS-1:0] instruction,
  output logic                     inst_valid
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e             state, state_next;
  logic [INST_ADDR_BUS-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0]            outstanding, discard, discard_next, count;
  logic [CW:0]              credit_used;
  fetch_entry_t             head, push_data;
  logic                     empty, full;
  logic                     q_pop, q_push, accept, keep, bypass;

  assign target = {redirect_addr[INST_ADDR_BUS-1:2], 2'b00};
  assign q_pop  = !empty && !stall && !redirect_enable;

  // The slot freed by this cycle's pop counts as free, which keeps one
  // instruction per cycle flowing with single-cycle memory and DEPTH = 2.
  assign credit_used = (CW+1)'(count) + (CW+1)'(outstanding) - (CW+1)'(q_pop);

  always_comb begin
    imem_request = (state != FETCH_BOOT) && !redirect_enable &&
                   (credit_used < (CW+1)'(DEPTH));
  end

  assign accept = imem_request && imem_ready;
  assign keep   = imem_valid && !redirect_enable && (discard == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = keep && empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word is consumed directly unless decode is stalled.
  assign q_push         = keep && !(bypass && !stall) && !full;
  assign push_data.pc   = resp_pc;
  assign push_data.word = imem_data;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_enable),
    .push      (q_push),
    .push_data (push_data),
    .pop       (q_pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Every request still in flight at a redirect (minus one landing now) is stale.
  always_comb begin
    discard_next = discard;
    if (redirect_enable)
      discard_next = outstanding - CW'(imem_valid);
    else if (imem_valid && (discard != '0))
      discard_next = discard - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_BOOT:  state_next = FETCH_RUN;
      FETCH_RUN:   if (discard_next != '0) state_next = FETCH_FLUSH;
      FETCH_FLUSH: if (discard_next == '0) state_next = FETCH_RUN;
      default:     state_next = FETCH_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH_BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      discard     <= discard_next;
      outstanding <= outstanding + CW'(accept) - CW'(imem_valid);
      if (redirect_enable) begin
        fetch_pc <= target;
        resp_pc  <= target;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (keep)   resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  assign imem_addr = fetch_pc;

  always_comb begin
    inst_valid      = !empty;
    program_counter = empty ? ZERO_WORD : head.pc;
    instruction     = empty ? ZERO_WORD : head.word;
    if (bypass) begin
      inst_valid      = 1'b1;
      program_counter = resp_pc;
      instruction     = imem_data;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: memory model with configurable latency/ready, in-order scoreboard.
module tb_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_VAL = 2;
  localparam int T1_RETIRE = 11;
`else
  localparam int FIRST_VAL = 3;
  localparam int T1_RETIRE = 10;
`endif

  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
  typedef struct { int due; logic [31:0] data; } mresp_t;

  logic        clock = 1'b0;
  logic        reset, stall, redirect_enable, imem_request, imem_ready, imem_valid, inst_valid;
  logic [31:0] redirect_addr, imem_addr, imem_data, program_counter, instruction;

  always #5 clock = ~clock;

  fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_enable (redirect_enable),
    .redirect_addr   (redirect_addr),
    .imem_request    (imem_request),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_valid      (imem_valid),
    .imem_data       (imem_data),
    .program_counter (program_counter),
    .instruction     (instruction),
    .inst_valid      (inst_valid)
  );

  exp_t        sb[$];
  mresp_t      mq[$];
  int          cmp_n = 0, fail_n = 0;
  int          cyc, lat, rmode, outst, acc_cnt, retired, first_req, first_val, cap_n;
  logic [31:0] exp_pc, first_pc;
  logic [31:0] acc_log [3];
  bit          got_first;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    cap_n = 0; got_first = 0; first_pc = 32'h1;
    for (int i = 0; i < 3; i++) acc_log[i] = 32'h1;
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; redirect_enable = 0;
    imem_valid = 0; imem_ready = 0; imem_data = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 0; cyc = 0; sb.delete(); mq.delete(); outst = 0;
    exp_pc = RESET_PC; first_req = -1; first_val = -1; retired = 0;
    clear_capture();
  endtask

  task automatic check_reset();
    #1;
    chk("rst_request", 32'(imem_request), 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_pc", program_counter, 0);
    chk("rst_inst", instruction, 0);
    chk("rst_valid", 32'(inst_valid), 0);
  endtask

  // One clock cycle: drive memory, sample outputs #1 later, update models.
  task automatic run_cycle();
    exp_t   e;
    mresp_t m;
    imem_valid = 0; imem_data = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_valid = 1; imem_data = mq[0].data; void'(mq.pop_front());
    end
    imem_ready = (rmode == 0) || (rmode == 1 && cyc % 2 == 0);
    #1;
    if (redirect_enable) begin
      chk("redir_no_req", 32'(imem_request), 0);
      sb.delete();
      exp_pc = {redirect_addr[31:2], 2'b00};
      clear_capture();
    end else if (inst_valid) begin
      if (sb.size() == 0) chk("spurious_valid", 32'(inst_valid), 0);
      else begin
        chk("out_pc", program_counter, sb[0].pc);
        chk("out_inst", instruction, sb[0].word);
        if (!got_first) begin first_pc = program_counter; got_first = 1; end
        if (first_val < 0) first_val = cyc;
        if (!stall) begin void'(sb.pop_front()); retired++; end
      end
    end else begin
      chk("idle_pc", program_counter, 0);
      chk("idle_inst", instruction, 0);
    end
    if (imem_request && first_req < 0) first_req = cyc;
    if (imem_request && imem_ready) begin
      chk("req_addr", imem_addr, exp_pc);
      if (cap_n < 3) acc_log[cap_n] = imem_addr;
      cap_n++;
      e.pc = exp_pc; e.word = memword(exp_pc); sb.push_back(e);
      m.due = cyc + lat; m.data = memword(imem_addr); mq.push_back(m);
      exp_pc += 32'd4; outst++; acc_cnt++;
    end
    if (imem_valid) outst--;
    chk("outst_le_depth", 32'(outst <= DEPTH), 1);
    @(negedge clock);
    cyc++;
  endtask

  // Stop issuing and let everything already requested reach decode.
  task automatic drain();
    int n = 0;
    stall = 0; redirect_enable = 0; rmode = 2;
    while ((sb.size() != 0 || outst != 0 || mq.size() != 0) && n < 60) begin
      run_cycle(); n++;
    end
    chk("drain_empty", 32'(sb.size() + outst), 0);
  endtask

  initial begin
    int n, a1, r0;
    lat = 1; rmode = 0; acc_cnt = 0; redirect_addr = '0;

    // Reset, sequential fetch with 1-cycle memory.
    do_reset();
    check_reset();
    repeat (13) run_cycle();
    chk("first_req_cycle", 32'(first_req), 1);
    chk("first_valid_cycle", 32'(first_val), FIRST_VAL);
    chk("steady_throughput", 32'(retired), T1_RETIRE);

    // Stall for 5 cycles: issue must stop, output held, no gap on release.
    stall = 1;
    repeat (2) run_cycle();
    a1 = acc_cnt;
    repeat (3) run_cycle();
    chk("stall_no_issue", 32'(acc_cnt - a1), 0);
    stall = 0;
    repeat (10) run_cycle();
    drain();

    // Redirect with two requests in flight.
    rmode = 0; lat = 3; n = 0;
    while (outst < 2 && n < 10) begin run_cycle(); n++; end
    chk("two_outstanding", 32'(outst), 2);
    redirect_enable = 1; redirect_addr = 32'h0000_0103;
    run_cycle();
    redirect_enable = 0;
    repeat (12) run_cycle();
    chk("redir_first_req", acc_log[0], 32'h0000_0100);
    chk("redir_first_pc", first_pc, 32'h0000_0100);
    drain();

    // Redirect coinciding with stall and a returning response.
    rmode = 0; lat = 2; n = 0;
    while (!(mq.size() > 0 && mq[0].due == cyc + 1) && n < 20) begin run_cycle(); n++; end
    stall = 1;
    run_cycle();
    redirect_enable = 1; redirect_addr = 32'h0000_2002;
    run_cycle();
    redirect_enable = 0; stall = 0;
    repeat (10) run_cycle();
    chk("coinc_first_req", acc_log[0], 32'h0000_2000);
    chk("coinc_first_pc", first_pc, 32'h0000_2000);
    drain();

    // Toggling ready, 3-cycle latency, occasional stalls.
    rmode = 1; lat = 3; r0 = retired;
    for (int i = 0; i < 40; i++) begin
      stall = (i % 7 == 3);
      run_cycle();
    end
    stall = 0;
    chk("toggle_progress", 32'(retired - r0 >= 8), 1);
    drain();

    // Address wrap at the top of the address space.
    rmode = 0; lat = 1;
    repeat (4) run_cycle();
    redirect_enable = 1; redirect_addr = 32'hFFFF_FFF8;
    run_cycle();
    redirect_enable = 0;
    repeat (8) run_cycle();
    chk("wrap_req0", acc_log[0], 32'hFFFF_FFF8);
    chk("wrap_req1", acc_log[1], 32'hFFFF_FFFC);
    chk("wrap_req2", acc_log[2], 32'h0000_0000);
    chk("wrap_first_pc", first_pc, 32'hFFFF_FFF8);
    drain();

    // Reset in the middle of streaming.
    rmode = 0; lat = 1;
    repeat (6) run_cycle();
    do_reset();
    check_reset();
    repeat (6) run_cycle();
    chk("rerst_first_req", 32'(first_req), 1);
    chk("rerst_first_pc", first_pc, RESET_PC);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
